// File: rtl/lpc_coeff_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : lpc_coeff_quantizer
// Purpose  : Captures a burst of IEEE-754 single LPC coefficients. When the
//            Durbin stage finishes, the block picks one common shift from the
//            largest exponent. It then emits every coefficient as a rounded,
//            saturated signed PRECISION-bit integer, one per cycle.
// Options  : LPC_QUANT_ERROR_FEEDBACK_EN - when defined, the rounding residual
//            of each coefficient is carried into the next one in index order.
// Revision : 1.0 - initial release
// ============================================================================
module lpc_coeff_quantizer #(
  parameter int MAX_ORDER = 12,
  parameter int PRECISION = 15,
  parameter int MAX_SHIFT = 15,
  parameter int FRAC_BITS = 16
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iEnable,
  input  logic [31:0]          iModel,
  input  logic                 iValid,
  input  logic                 iDone,
  output logic [PRECISION-1:0] oCoeff,
  output logic [3:0]           oIndex,
  output logic [3:0]           oShift,
  output logic [3:0]           oOrder,
  output logic                 oValid,
  output logic                 oOverflow,
  output logic                 oDone
);

  // Magnitude keeps PRECISION integer bits plus headroom above FRAC_BITS
  // fraction bits. The signed sum adds a sign bit and room for the residual.
  localparam int MAG_W = PRECISION + FRAC_BITS + 2;
  localparam int SUM_W = MAG_W + 2;

  localparam logic [3:0]             ORDER_LIM    = 4'(MAX_ORDER);
  localparam logic [SUM_W-1:0]       HALF_LSB     = SUM_W'(1) << (FRAC_BITS - 1);
  localparam logic [SUM_W-1:0]       POS_LIM      = SUM_W'((2 ** (PRECISION - 1)) - 1);
  localparam logic [SUM_W-1:0]       NEG_LIM      = SUM_W'(2 ** (PRECISION - 1));
  localparam logic [PRECISION-1:0]   COEFF_MAX    = {1'b0, {(PRECISION - 1){1'b1}}};
  localparam logic [PRECISION-1:0]   COEFF_MIN    = {1'b1, {(PRECISION - 1){1'b0}}};
  localparam logic signed [10:0]     SHIFT_TARGET = 11'(PRECISION - 2);
  localparam logic signed [10:0]     SHIFT_LIM    = 11'(MAX_SHIFT);
  localparam logic signed [10:0]     ALIGN_BIAS   = 11'(FRAC_BITS - 150);
  localparam logic signed [10:0]     ALIGN_MAX    = 11'(MAG_W - 24);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SCAN    = 3'd2,
    S_SHIFT   = 3'd3,
    S_QUANT   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_next;

  logic [31:0]               coeff_mem [MAX_ORDER];
  logic [3:0]                count, count_after, wr_ptr, idx;
  logic                      prev_valid, capture_en, wr_en, last_item;
  logic signed [9:0]         emax, scan_ev;
  logic                      any_nz;
  logic [31:0]               rd_word;
  logic                      rd_sign;
  logic [7:0]                rd_exp;
  logic [22:0]               rd_mant;
  logic signed [10:0]        shift_raw, align;
  logic [10:0]               neg_align;
  logic [3:0]                shift_calc;
  logic [MAG_W-1:0]          mant_ext, mag;
  logic signed [SUM_W-1:0]   f_signed, sum;
  logic                      sum_neg;
  logic [SUM_W-1:0]          abs_sum, q_mag;
  logic [PRECISION-1:0]      q_coeff;
  logic                      q_sat;
  logic signed [FRAC_BITS-1:0] res;

  // Burst bookkeeping: a fresh run of iValid restarts at index 0, overflow words are dropped
  always_comb begin
    capture_en  = iEnable && iValid && (state == S_IDLE || state == S_CAPTURE);
    wr_ptr      = prev_valid ? count : 4'd0;
    wr_en       = capture_en && (wr_ptr < ORDER_LIM);
    count_after = count;
    if (capture_en) begin
      count_after = wr_en ? (wr_ptr + 4'd1) : wr_ptr;
    end
    last_item   = (idx == (count - 4'd1));
  end

  // Coefficient buffer write port
  always_ff @(posedge iClock) begin
    if (wr_en) begin
      coeff_mem[wr_ptr] <= iModel;
    end
  end

  // FSM state register
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; an empty buffer on iDone skips straight to DONE
  always_comb begin
    state_next = state;
    if (iEnable) begin
      case (state)
        S_IDLE: begin
          if (iDone) begin
            state_next = (count_after == 4'd0) ? S_DONE : S_SCAN;
          end else if (capture_en) begin
            state_next = S_CAPTURE;
          end
        end
        S_CAPTURE: if (iDone) state_next = S_SCAN;
        S_SCAN:    if (last_item) state_next = S_SHIFT;
        S_SHIFT:   state_next = S_QUANT;
        S_QUANT:   if (last_item) state_next = S_DONE;
        S_DONE:    state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Decode, shift selection, alignment, rounding and saturation of the word at idx
  always_comb begin
    rd_word   = coeff_mem[idx];
    rd_sign   = rd_word[31];
    rd_exp    = rd_word[30:23];
    rd_mant   = rd_word[22:0];
    scan_ev   = $signed({2'b00, rd_exp}) - 10'sd127;

    shift_raw = SHIFT_TARGET - {emax[9], emax};
    if (!any_nz || (shift_raw < 0)) begin
      shift_calc = 4'd0;
    end else if (shift_raw > SHIFT_LIM) begin
      shift_calc = 4'(MAX_SHIFT);
    end else begin
      shift_calc = shift_raw[3:0];
    end

    // Bit position of the hidden 1 relative to the fixed-point LSB
    align     = $signed({3'b000, rd_exp}) + $signed({7'b0000000, oShift}) + ALIGN_BIAS;
    neg_align = -align;
    mant_ext  = {{(MAG_W - 24){1'b0}}, 1'b1, rd_mant};
    if (rd_exp == 8'd0) begin
      mag = '0;
    end else if (rd_exp == 8'hFF) begin
      mag = '1;
    end else if (align < 0) begin
      mag = (neg_align >= 11'd24) ? '0 : (mant_ext >> neg_align);
    end else if (align > ALIGN_MAX) begin
      mag = '1;
    end else begin
      mag = mant_ext << align;
    end

    f_signed = $signed({2'b00, mag});
    if (rd_sign) begin
      f_signed = -f_signed;
    end
    sum     = f_signed + {{(SUM_W - FRAC_BITS){res[FRAC_BITS-1]}}, res};
    sum_neg = sum[SUM_W-1];
    abs_sum = sum_neg ? -sum : sum;
    q_mag   = (abs_sum + HALF_LSB) >> FRAC_BITS;

    q_sat   = 1'b0;
    if (!sum_neg && (q_mag > POS_LIM)) begin
      q_coeff = COEFF_MAX;
      q_sat   = 1'b1;
    end else if (sum_neg && (q_mag > NEG_LIM)) begin
      q_coeff = COEFF_MIN;
      q_sat   = 1'b1;
    end else begin
      q_coeff = sum_neg ? PRECISION'(-q_mag) : PRECISION'(q_mag);
    end
  end

`ifdef LPC_QUANT_ERROR_FEEDBACK_EN
  // Residual carry: q is a whole number of FRAC_BITS units, so s - q keeps the low bits of s
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      res <= '0;
    end else if (iEnable) begin
      if (state == S_SHIFT) begin
        res <= '0;
      end else if (state == S_QUANT) begin
        res <= sum[FRAC_BITS-1:0];
      end
    end
  end
`else
  assign res = '0;
`endif

  // Counters, exponent scan and registered outputs
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      count      <= 4'd0;
      prev_valid <= 1'b0;
      idx        <= 4'd0;
      emax       <= '0;
      any_nz     <= 1'b0;
      oCoeff     <= '0;
      oIndex     <= 4'd0;
      oShift     <= 4'd0;
      oOrder     <= 4'd0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oDone      <= 1'b0;
    end else if (iEnable) begin
      prev_valid <= iValid && (state == S_IDLE || state == S_CAPTURE);
      count      <= count_after;
      oValid     <= 1'b0;
      oDone      <= 1'b0;
      case (state)
        S_IDLE, S_CAPTURE: begin
          idx    <= 4'd0;
          any_nz <= 1'b0;
          emax   <= '0;
          if (iDone) begin
            oOverflow <= 1'b0;
            if (state_next == S_DONE) begin
              oOrder <= 4'd0;
              oShift <= 4'd0;
            end
          end
        end
        S_SCAN: begin
          if (rd_exp != 8'd0) begin
            any_nz <= 1'b1;
            if (!any_nz || (scan_ev > emax)) begin
              emax <= scan_ev;
            end
          end
          idx <= last_item ? 4'd0 : (idx + 4'd1);
        end
        S_SHIFT: begin
          oShift <= shift_calc;
          oOrder <= count;
          idx    <= 4'd0;
        end
        S_QUANT: begin
          oValid <= 1'b1;
          oCoeff <= q_coeff;
          oIndex <= idx;
          if (q_sat) begin
            oOverflow <= 1'b1;
          end
          idx <= last_item ? 4'd0 : (idx + 4'd1);
        end
        S_DONE: begin
          oDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
